// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract: one shared full adder, LSB first, one bit per clock; result after WIDTH clocks.
// Accepts only in IDLE (in_ready); result and flags held in DONE until out_ready.

module fulladder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   a_sh, b_sh, res_sh;
   logic               carry;
   logic [CNT_W-1:0]   cnt;
   logic               ovf_r;
   logic               load;
   logic               last_bit;
   logic               fa_sum, fa_cout;

   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   fulladder u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      load      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last_bit) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         ovf_r  <= 1'b0;
      end else if (load) begin
         a_sh   <= a;
         b_sh   <= op_sub ? ~b : b;
         carry  <= op_sub;
         cnt    <= '0;
         res_sh <= '0;
      end else if (state == RUN) begin
         res_sh <= {fa_sum, res_sh[WIDTH-1:1]};
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         carry  <= fa_cout;
         if (last_bit) ovf_r <= carry ^ fa_cout;
         else          cnt   <= cnt + 1'b1;
      end
   end

   assign result = (state == DONE) ? res_sh : '0;
   assign cout   = (state == DONE) ? carry  : 1'b0;
   assign ovf    = (state == DONE) ? ovf_r  : 1'b0;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): directed table, reset abort, random back-to-back stream.
module tb_serial_adder_ctrl;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic         op_sub;
   logic [W-1:0] a, b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_sub    (op_sub),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         op;
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic [W-1:0] res;
      logic         co;
      logic         ov;
      int           hold;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Reference: plain integer arithmetic, {ovf, cout, result}.
   function automatic logic [W+1:0] model(input logic op, input logic [W-1:0] xa, input logic [W-1:0] xb);
      int ua, ub, sa, sb, s, r;
      logic co, ov;
      ua = int'(xa);
      ub = int'(xb);
      sa = ua >= 128 ? ua - 256 : ua;
      sb = ub >= 128 ? ub - 256 : ub;
      if (!op) begin
         r  = (ua + ub) % 256;
         co = (ua + ub) > 255;
         s  = sa + sb;
      end else begin
         r  = (ua - ub + 256) % 256;
         co = (ua >= ub);
         s  = sa - sb;
      end
      ov = (s > 127) || (s < -128);
      return {ov, co, r[W-1:0]};
   endfunction

   task automatic do_op(input vec_t v);
      int n;
      logic [W-1:0] r0;
      logic c0, o0;
      out_ready = (v.hold == 0);
      op_sub = v.op; a = v.va; b = v.vb; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 40) begin step(); n++; end
      chk("in_ready_before_accept", in_ready, 1);
      step();
      // Junk operands offered while busy must not be sampled.
      a = 8'($urandom); b = 8'($urandom); op_sub = 1'($urandom);
      n = 0;
      while (!out_valid && n < 40) begin
         chk("in_ready_busy", in_ready, 0);
         step();
         n++;
      end
      chk("latency", n, W);
      chk("result", result, v.res);
      chk("cout", cout, v.co);
      chk("ovf", ovf, v.ov);
      r0 = result; c0 = cout; o0 = ovf;
      for (int i = 0; i < v.hold; i++) begin
         step();
         chk("hold_valid", out_valid, 1);
         chk("hold_ready", in_ready, 0);
         chk("hold_stable", {result, cout, ovf}, {r0, c0, o0});
      end
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("release_valid", out_valid, 0);
      chk("release_ready", in_ready, 1);
      chk("release_result", result, 0);
   endtask

   vec_t vecs[$];

   initial begin
      int issued, done, last_t, timeout;
      logic [W+1:0] expq[$];
      logic [W+1:0] e;

      vecs = '{
         '{1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 0},
         '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0},
         '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 0},
         '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 0},
         '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 5},
         '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 2},
         '{1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 0},
         '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1, 1},
         '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0}
      };

      rst_n = 1'b0; in_valid = 1'b0; op_sub = 1'b0; a = '0; b = '0; out_ready = 1'b0;
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_outputs", {result, cout, ovf}, 0);
      step();
      rst_n = 1'b1;
      step();

      foreach (vecs[i]) do_op(vecs[i]);

      // Reset in mid-RUN at cnt==3 aborts the operation.
      op_sub = 1'b0; a = 8'h11; b = 8'h22; in_valid = 1'b1;
      chk("abort_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      step(); step(); step();
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_result", result, 0);
      #1 rst_n = 1'b1;
      step();
      chk("abort_idle_no_output", out_valid, 0);
      do_op('{1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 0});

      // Random back-to-back stream, in_valid/out_ready held high.
      issued = 0; done = 0; last_t = -1; timeout = 0;
      out_ready = 1'b1;
      op_sub = 1'($urandom); a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
      while (done < 1000 && !timeout) begin
         logic acc;
         acc = in_valid && in_ready;
         if (acc) expq.push_back(model(op_sub, a, b));
         step();
         if (acc) begin
            issued++;
            in_valid = (issued < 1000);
            op_sub = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
         end
         if (out_valid) begin
            if (expq.size() == 0) begin
               chk("b2b_unexpected_result", 1, 0);
            end else begin
               e = expq.pop_front();
               chk("b2b_result", {ovf, cout, result}, e);
               if (last_t >= 0) chk("b2b_spacing", cyc - last_t, W + 2);
            end
            last_t = cyc;
            done++;
         end
         if (cyc > 20000) timeout = 1;
      end
      chk("b2b_completed", done, 1000);
      in_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
